// File: rtl/pepelatz_pkg.sv
// -----------------------------------------------------------------------------
// pepelatz_pkg
//   Shared definitions for the Pepelatz MISC core stacks: opcode encodings,
//   opcode width and a decode helper that reports, for each opcode, how many
//   elements it needs and whether it grows or shrinks the stack by one.
// -----------------------------------------------------------------------------
package pepelatz_pkg;

    localparam int STACK_OP_W = 3;

    localparam logic [STACK_OP_W-1:0] OP_NOP       = 3'd0;
    localparam logic [STACK_OP_W-1:0] OP_PUSH      = 3'd1;
    localparam logic [STACK_OP_W-1:0] OP_POP       = 3'd2;
    localparam logic [STACK_OP_W-1:0] OP_DUP       = 3'd3;
    localparam logic [STACK_OP_W-1:0] OP_SWAP      = 3'd4;
    localparam logic [STACK_OP_W-1:0] OP_OVER      = 3'd5;
    localparam logic [STACK_OP_W-1:0] OP_REPLACE   = 3'd6;
    localparam logic [STACK_OP_W-1:0] OP_POP2_PUSH = 3'd7;

    // Static properties of one opcode.
    typedef struct packed {
        logic [1:0] need;    // elements that must already be on the stack
        logic       grow;    // depth +1
        logic       shrink;  // depth -1
    } op_info_t;

    function automatic op_info_t decode_op(input logic [STACK_OP_W-1:0] op);
        op_info_t info;
        info = '{need: 2'd0, grow: 1'b0, shrink: 1'b0};
        case (op)
            OP_PUSH:      info = '{need: 2'd0, grow: 1'b1, shrink: 1'b0};
            OP_POP:       info = '{need: 2'd1, grow: 1'b0, shrink: 1'b1};
            OP_DUP:       info = '{need: 2'd1, grow: 1'b1, shrink: 1'b0};
            OP_SWAP:      info = '{need: 2'd2, grow: 1'b0, shrink: 1'b0};
            OP_OVER:      info = '{need: 2'd2, grow: 1'b1, shrink: 1'b0};
            OP_REPLACE:   info = '{need: 2'd1, grow: 1'b0, shrink: 1'b0};
            OP_POP2_PUSH: info = '{need: 2'd2, grow: 1'b0, shrink: 1'b1};
            default:      info = '{need: 2'd0, grow: 1'b0, shrink: 1'b0};
        endcase
        return info;
    endfunction

endpackage

// File: rtl/pepelatz_stack_ram.sv
// -----------------------------------------------------------------------------
// pepelatz_stack_ram
//   Spill array for the elements below TOS/NOS. One synchronous write port,
//   one asynchronous read port, no reset.
// Ports
//   clk    in   1        write clock, rising edge
//   we     in   1        write enable
//   waddr  in   ADDR_W   write address
//   wdata  in   WIDTH    write data
//   raddr  in   ADDR_W   read address
//   rdata  out  WIDTH    read data (combinational); 0 for addresses past the array
// -----------------------------------------------------------------------------
module pepelatz_stack_ram #(
    parameter int WIDTH   = 16,
    parameter int ENTRIES = 62,
    parameter int ADDR_W  = 6
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [ENTRIES];

    // NOTE: the array has no reset branch on purpose; resetting storage turns a
    // compact register file into a wide reset fan-out for data nobody may read.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // The read address is computed speculatively from depth and can point past
    // the array when no refill is needed; return 0 there instead of X.
    assign rdata = (int'(raddr) < ENTRIES) ? mem[raddr] : '0;

endmodule

// File: rtl/pepelatz_stack.sv
// -----------------------------------------------------------------------------
// pepelatz_stack
//   Parametrised LIFO with the top two entries cached in registers (tos/nos)
//   and the remaining DEPTH-2 entries kept in pepelatz_stack_ram. Every opcode
//   completes in one cycle; sticky flags record overflow and underflow.
// Ports
//   clk        in   1         clock, rising edge
//   rst        in   1         asynchronous active-high reset
//   op_valid   in   1         op sampled on the rising edge when high
//   op         in   3         opcode (pepelatz_pkg::OP_*)
//   push_data  in   WIDTH     data for PUSH / REPLACE / POP2_PUSH
//   clear_err  in   1         clears the sticky error flags
//   tos        out  WIDTH     top of stack
//   nos        out  WIDTH     next on stack
//   depth      out  PTR_W+1   element count, 0..DEPTH
//   empty      out  1         depth == 0
//   full       out  1         depth == DEPTH
//   overflow   out  1         sticky: a growing op was issued when full
//   underflow  out  1         sticky: an op needed more elements than present
// -----------------------------------------------------------------------------
module pepelatz_stack
    import pepelatz_pkg::*;
#(
    parameter  int WIDTH = 16,
    parameter  int DEPTH = 64,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  op_valid,
    input  logic [STACK_OP_W-1:0] op,
    input  logic [WIDTH-1:0]      push_data,
    input  logic                  clear_err,
    output logic [WIDTH-1:0]      tos,
    output logic [WIDTH-1:0]      nos,
    output logic [PTR_W:0]        depth,
    output logic                  empty,
    output logic                  full,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int DEP_W = PTR_W + 1;
    localparam logic [DEP_W-1:0] DEPTH_MAX = DEP_W'(DEPTH);

    // Next-state values
    logic [WIDTH-1:0] tos_n;
    logic [WIDTH-1:0] nos_n;
    logic [DEP_W-1:0] depth_n;
    logic             overflow_n;
    logic             underflow_n;

    // Decode / error detection
    op_info_t info;
    logic     ovf_hit;
    logic     unf_hit;
    logic     do_op;

    // Spill array interface
    logic             ram_we;
    logic [PTR_W-1:0] ram_waddr;
    logic [PTR_W-1:0] ram_raddr;
    logic [WIDTH-1:0] ram_rdata;
    logic [WIDTH-1:0] fill_val;

    // The element that moves between nos and the array: a growing op spills nos
    // into elem[depth-2], a shrinking op refills nos from elem[depth-3]. Only the
    // low PTR_W bits matter; at depth==DEPTH the write is blocked by ovf_hit.
    assign ram_waddr = depth[PTR_W-1:0] - PTR_W'(2);
    assign ram_raddr = depth[PTR_W-1:0] - PTR_W'(3);

    pepelatz_stack_ram #(
        .WIDTH   (WIDTH),
        .ENTRIES (DEPTH - 2),
        .ADDR_W  (PTR_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (nos),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

    // Error detection. Overflow is checked first so that DUP/OVER on a full
    // stack report overflow only.
    always_comb begin
        info    = decode_op(op);
        ovf_hit = op_valid && info.grow && (depth == DEPTH_MAX);
        unf_hit = op_valid && !ovf_hit && (depth < DEP_W'(info.need));
        do_op   = op_valid && !ovf_hit && !unf_hit;
    end

    // Datapath next state. An errored op leaves everything except the flags
    // untouched.
    // NOTE: every variable gets its hold value before the case, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        tos_n    = tos;
        nos_n    = nos;
        depth_n  = depth;
        ram_we   = 1'b0;
        // With fewer than three elements there is nothing below nos: zero-fill.
        fill_val = (depth >= DEP_W'(3)) ? ram_rdata : '0;

        if (do_op) begin
            case (op)
                OP_PUSH: begin
                    tos_n = push_data;
                    nos_n = tos;
                end
                OP_POP: begin
                    tos_n = nos;
                    nos_n = fill_val;
                end
                OP_DUP: begin
                    nos_n = tos;
                end
                OP_SWAP, OP_OVER: begin
                    tos_n = nos;
                    nos_n = tos;
                end
                OP_REPLACE: begin
                    tos_n = push_data;
                end
                OP_POP2_PUSH: begin
                    tos_n = push_data;
                    nos_n = fill_val;
                end
                default: begin
                end
            endcase

            if (info.grow) begin
                depth_n = depth + DEP_W'(1);
                ram_we  = (depth >= DEP_W'(2));
            end else if (info.shrink) begin
                depth_n = depth - DEP_W'(1);
            end
        end
    end

    // Sticky flags: a new error in the same cycle as clear_err wins.
    always_comb begin
        overflow_n  = ovf_hit ? 1'b1 : (clear_err ? 1'b0 : overflow);
        underflow_n = unf_hit ? 1'b1 : (clear_err ? 1'b0 : underflow);
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tos       <= '0;
            nos       <= '0;
            depth     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            tos       <= tos_n;
            nos       <= nos_n;
            depth     <= depth_n;
            overflow  <= overflow_n;
            underflow <= underflow_n;
        end
    end

    assign empty = (depth == '0);
    assign full  = (depth == DEPTH_MAX);

endmodule
